// File: rtl/cursor_tracker_if.sv
// rtl/cursor_tracker_if.sv - mouse packet in / cursor state out bundle for cursor_tracker
interface cursor_tracker_if #(
  parameter int X_BITS  = 10,
  parameter int Y_BITS  = 9,
  parameter int NUM_BTN = 3
);
  logic                m_done_tick;
  logic [8:0]          xm;
  logic [8:0]          ym;
  logic [NUM_BTN-1:0]  btnm;
  logic                freeze;
  logic [X_BITS-1:0]   pos_x;
  logic [Y_BITS-1:0]   pos_y;
  logic                pos_valid;
  logic [NUM_BTN-1:0]  buttons;
  logic [NUM_BTN-1:0]  press;
  logic [NUM_BTN-1:0]  btn_release;
  logic [X_BITS-1:0]   click_x;
  logic [Y_BITS-1:0]   click_y;

  modport master (
    output m_done_tick, xm, ym, btnm, freeze,
    input  pos_x, pos_y, pos_valid, buttons, press, btn_release, click_x, click_y
  );

  modport slave (
    input  m_done_tick, xm, ym, btnm, freeze,
    output pos_x, pos_y, pos_valid, buttons, press, btn_release, click_x, click_y
  );
endinterface

// File: rtl/cursor_tracker.sv
// rtl/cursor_tracker.sv - two-stage mouse delta accumulator with clamped cursor and button tracking
// S1 captures scaled deltas and buttons; S2 clamps the new position and runs the button FSMs.
module cursor_tracker #(
  parameter int X_BITS      = 10,
  parameter int Y_BITS      = 9,
  parameter int MAX_X       = 635,
  parameter int MAX_Y       = 475,
  parameter int SPEED_SHIFT = 0,
  parameter int Y_INVERT    = 1,
  parameter int NUM_BTN     = 3
) (
  input  logic           i_clk,
  input  logic           i_reset,
  cursor_tracker_if.slave io_bus
);
  localparam int WX = X_BITS + SPEED_SHIFT + 3;
  localparam int WY = Y_BITS + SPEED_SHIFT + 3;
  localparam logic [0:0] ST_UP   = 1'b0;
  localparam logic [0:0] ST_DOWN = 1'b1;
  localparam logic signed [WX-1:0] C_MAX_X = WX'(MAX_X);
  localparam logic signed [WY-1:0] C_MAX_Y = WY'(MAX_Y);

  logic                     r_s1_valid;
  logic signed [WX-1:0]     r_dx;
  logic signed [WY-1:0]     r_dy;
  logic [NUM_BTN-1:0]       r_s1_btn;
  logic [X_BITS-1:0]        r_pos_x;
  logic [Y_BITS-1:0]        r_pos_y;
  logic                     r_pos_valid;
  logic [NUM_BTN-1:0]       r_state;
  logic [NUM_BTN-1:0]       r_press;
  logic [NUM_BTN-1:0]       r_release;
  logic [X_BITS-1:0]        r_click_x;
  logic [Y_BITS-1:0]        r_click_y;

  logic signed [WX-1:0]     w_dx;
  logic signed [WY-1:0]     w_dy_raw;
  logic signed [WY-1:0]     w_dy;
  logic signed [WX-1:0]     w_nx;
  logic signed [WY-1:0]     w_ny;
  logic [X_BITS-1:0]        w_cx;
  logic [Y_BITS-1:0]        w_cy;
  logic [X_BITS-1:0]        w_upd_x;
  logic [Y_BITS-1:0]        w_upd_y;
  logic [NUM_BTN-1:0]       w_next;
  logic [NUM_BTN-1:0]       w_press;
  logic [NUM_BTN-1:0]       w_release;

  always_comb begin
    w_dx     = $signed({{(WX-9){io_bus.xm[8]}}, io_bus.xm}) <<< SPEED_SHIFT;
    w_dy_raw = $signed({{(WY-9){io_bus.ym[8]}}, io_bus.ym}) <<< SPEED_SHIFT;
    w_dy     = (Y_INVERT != 0) ? -w_dy_raw : w_dy_raw;

    // Widened by SPEED_SHIFT+3 so a full-scale negative delta cannot wrap before the clamp.
    w_nx = $signed({{(SPEED_SHIFT+3){1'b0}}, r_pos_x}) + r_dx;
    w_ny = $signed({{(SPEED_SHIFT+3){1'b0}}, r_pos_y}) + r_dy;

    if (w_nx[WX-1])         w_cx = '0;
    else if (w_nx > C_MAX_X) w_cx = X_BITS'(MAX_X);
    else                    w_cx = w_nx[X_BITS-1:0];

    if (w_ny[WY-1])         w_cy = '0;
    else if (w_ny > C_MAX_Y) w_cy = Y_BITS'(MAX_Y);
    else                    w_cy = w_ny[Y_BITS-1:0];

    w_upd_x = io_bus.freeze ? r_pos_x : w_cx;
    w_upd_y = io_bus.freeze ? r_pos_y : w_cy;
  end

  always_comb begin
    w_next    = r_state;
    w_press   = '0;
    w_release = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      case (r_state[i])
        ST_UP:   if (r_s1_btn[i])  begin w_next[i] = ST_DOWN; w_press[i]   = 1'b1; end
        ST_DOWN: if (!r_s1_btn[i]) begin w_next[i] = ST_UP;   w_release[i] = 1'b1; end
        default: w_next[i] = ST_UP;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_s1_valid  <= 1'b0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_s1_btn    <= '0;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_pos_valid <= 1'b0;
      r_state     <= '0;
      r_press     <= '0;
      r_release   <= '0;
      r_click_x   <= '0;
      r_click_y   <= '0;
    end else begin
      r_s1_valid  <= io_bus.m_done_tick;
      r_pos_valid <= r_s1_valid;
      r_press     <= '0;
      r_release   <= '0;
      if (io_bus.m_done_tick) begin
        r_dx     <= w_dx;
        r_dy     <= w_dy;
        r_s1_btn <= io_bus.btnm;
      end
      if (r_s1_valid) begin
        r_pos_x   <= w_upd_x;
        r_pos_y   <= w_upd_y;
        r_state   <= w_next;
        r_press   <= w_press;
        r_release <= w_release;
        if (w_press[0]) begin
          r_click_x <= w_upd_x;
          r_click_y <= w_upd_y;
        end
      end
    end
  end

  assign io_bus.pos_x       = r_pos_x;
  assign io_bus.pos_y       = r_pos_y;
  assign io_bus.pos_valid   = r_pos_valid;
  assign io_bus.buttons     = r_state;
  assign io_bus.press       = r_press;
  assign io_bus.btn_release = r_release;
  assign io_bus.click_x     = r_click_x;
  assign io_bus.click_y     = r_click_y;
endmodule

// File: tb/tb_cursor_tracker.sv
// tb/tb_cursor_tracker.sv - randomized bench for cursor_tracker against a behavioural model
module tb_cursor_tracker;
  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       frz;
  logic [8:0] xm;
  logic [8:0] ym;
  logic [2:0] btn;
  int         checks;
  int         errors;

  cursor_tracker_if #(.X_BITS(10), .Y_BITS(9), .NUM_BTN(3)) if0 ();
  cursor_tracker_if #(.X_BITS(10), .Y_BITS(9), .NUM_BTN(3)) if1 ();
  cursor_tracker_if #(.X_BITS(10), .Y_BITS(9), .NUM_BTN(3)) if2 ();

  cursor_tracker #(.SPEED_SHIFT(0), .Y_INVERT(1)) dut0 (.i_clk(clk), .i_reset(rst_n), .io_bus(if0));
  cursor_tracker #(.SPEED_SHIFT(2), .Y_INVERT(0)) dut1 (.i_clk(clk), .i_reset(rst_n), .io_bus(if1));
  cursor_tracker #(.SPEED_SHIFT(3), .Y_INVERT(1)) dut2 (.i_clk(clk), .i_reset(rst_n), .io_bus(if2));

  assign if0.m_done_tick = tick; assign if0.xm = xm; assign if0.ym = ym; assign if0.btnm = btn; assign if0.freeze = frz;
  assign if1.m_done_tick = tick; assign if1.xm = xm; assign if1.ym = ym; assign if1.btnm = btn; assign if1.freeze = frz;
  assign if2.m_done_tick = tick; assign if2.xm = xm; assign if2.ym = ym; assign if2.btnm = btn; assign if2.freeze = frz;

  logic [9:0] ox[3];
  logic [8:0] oy[3];
  logic       ov[3];
  logic [2:0] ob[3];
  logic [2:0] op[3];
  logic [2:0] orel[3];
  logic [9:0] ocx[3];
  logic [8:0] ocy[3];

  assign ox[0] = if0.pos_x;  assign oy[0] = if0.pos_y;  assign ov[0] = if0.pos_valid;
  assign ob[0] = if0.buttons; assign op[0] = if0.press; assign orel[0] = if0.btn_release;
  assign ocx[0] = if0.click_x; assign ocy[0] = if0.click_y;
  assign ox[1] = if1.pos_x;  assign oy[1] = if1.pos_y;  assign ov[1] = if1.pos_valid;
  assign ob[1] = if1.buttons; assign op[1] = if1.press; assign orel[1] = if1.btn_release;
  assign ocx[1] = if1.click_x; assign ocy[1] = if1.click_y;
  assign ox[2] = if2.pos_x;  assign oy[2] = if2.pos_y;  assign ov[2] = if2.pos_valid;
  assign ob[2] = if2.buttons; assign op[2] = if2.press; assign orel[2] = if2.btn_release;
  assign ocx[2] = if2.click_x; assign ocy[2] = if2.click_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cursor as plain integers, buttons as last seen levels.
  int         ss[3] = '{0, 2, 3};
  int         yi[3] = '{1, 0, 1};
  int         mx[3];
  int         my[3];
  int         cx[3];
  int         cy[3];
  logic [2:0] mb;
  logic [2:0] ep;
  logic [2:0] er;

  function automatic int clampi(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin mx[k] = 0; my[k] = 0; cx[k] = 0; cy[k] = 0; end
    mb = 3'b000; ep = 3'b000; er = 3'b000;
  endfunction

  function automatic void model_apply(int x, int y, logic [2:0] b, bit f);
    for (int k = 0; k < 3; k++) begin
      if (!f) begin
        mx[k] = clampi(mx[k] + x * (1 << ss[k]), 635);
        my[k] = clampi(my[k] + (yi[k] != 0 ? -y : y) * (1 << ss[k]), 475);
      end
    end
    ep = b & ~mb;
    er = ~b & mb;
    mb = b;
    if (ep[0]) for (int k = 0; k < 3; k++) begin cx[k] = mx[k]; cy[k] = my[k]; end
  endfunction

  function automatic int rnd_delta();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic send(input int x, input int y, input logic [2:0] b, input bit f);
    tick = 1'b1; xm = 9'(x); ym = 9'(y); btn = b; frz = f;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    frz = 1'b0;
    model_apply(x, y, b, f);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0; frz = 1'b0; xm = '0; ym = '0; btn = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || ox[k] !== 10'd0 || oy[k] !== 9'd0 || ob[k] !== 3'b0 || op[k] !== 3'b0 ||
          orel[k] !== 3'b0 || ocx[k] !== 10'd0 || ocy[k] !== 9'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d] got v=%0b pos=(%0d,%0d) b=%b p=%b r=%b click=(%0d,%0d) exp all zero",
                 k, ov[k], ox[k], oy[k], ob[k], op[k], orel[k], ocx[k], ocy[k]);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ov[k] !== 1'b0) begin errors++; $display("FAIL idle_no_valid[%0d] got %0b exp 0", k, ov[k]); end
      end
    end
  endtask

  task automatic test_basic_move();
    send(5, -3, 3'b000, 1'b0);
    checks++;
    if (ox[0] !== 10'd5 || oy[0] !== 9'd3 || ov[0] !== 1'b1) begin
      errors++; $display("FAIL move_5_m3 got v=%0b (%0d,%0d) exp v=1 (5,3)", ov[0], ox[0], oy[0]);
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b1 || ox[k] !== 10'(mx[k]) || oy[k] !== 9'(my[k])) begin
        errors++; $display("FAIL move_scaled[%0d] got v=%0b (%0d,%0d) exp v=1 (%0d,%0d)", k, ov[k], ox[k], oy[k], mx[k], my[k]);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b0) begin errors++; $display("FAIL valid_one_cycle[%0d] got %0b exp 0", k, ov[k]); end
    end
  endtask

  task automatic test_clamp();
    send(-3, 0, 3'b000, 1'b0);
    send(-3, 0, 3'b000, 1'b0);
    checks++;
    if (ox[0] !== 10'd0) begin errors++; $display("FAIL clamp_low got %0d exp 0", ox[0]); end
    send(255, 0, 3'b000, 1'b0);
    send(255, 0, 3'b000, 1'b0);
    send(200, 0, 3'b000, 1'b0);
    checks++;
    if (ox[0] !== 10'd635) begin errors++; $display("FAIL clamp_high got %0d exp 635", ox[0]); end
    send(1, 255, 3'b000, 1'b0);
    send(0, 255, 3'b000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ox[k] !== 10'(mx[k]) || oy[k] !== 9'(my[k])) begin
        errors++; $display("FAIL clamp_hold[%0d] got (%0d,%0d) exp (%0d,%0d)", k, ox[k], oy[k], mx[k], my[k]);
      end
    end
    send(-256, 255, 3'b000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ox[k] !== 10'(mx[k]) || oy[k] !== 9'(my[k])) begin
        errors++; $display("FAIL clamp_min256[%0d] got (%0d,%0d) exp (%0d,%0d)", k, ox[k], oy[k], mx[k], my[k]);
      end
    end
  endtask

  task automatic test_buttons();
    int kx0;
    int ky0;
    send(7, -4, 3'b001, 1'b0);
    kx0 = mx[0]; ky0 = my[0];
    checks++;
    if (op[0] !== 3'b001 || orel[0] !== 3'b000) begin
      errors++; $display("FAIL press_first got p=%b r=%b exp p=001 r=000", op[0], orel[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (op[0] !== 3'b000) begin errors++; $display("FAIL press_pulse_width got %b exp 000", op[0]); end
    for (int n = 0; n < 2; n++) begin
      send(3, 2, 3'b001, 1'b0);
      checks++;
      if (op[0] !== 3'b000 || ob[0] !== 3'b001) begin
        errors++; $display("FAIL press_held[%0d] got p=%b b=%b exp p=000 b=001", n, op[0], ob[0]);
      end
    end
    send(-2, 1, 3'b000, 1'b0);
    checks++;
    if (orel[0] !== 3'b001 || op[0] !== 3'b000 || ob[0] !== 3'b000) begin
      errors++; $display("FAIL release_fourth got r=%b p=%b b=%b exp r=001 p=000 b=000", orel[0], op[0], ob[0]);
    end
    checks++;
    if (ocx[0] !== 10'(kx0) || ocy[0] !== 9'(ky0)) begin
      errors++; $display("FAIL click_latch got (%0d,%0d) exp (%0d,%0d)", ocx[0], ocy[0], kx0, ky0);
    end
  endtask

  task automatic test_freeze();
    send(10, 5, 3'b010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b1 || ox[k] !== 10'(mx[k]) || oy[k] !== 9'(my[k]) || ob[k] !== 3'b010 || op[k] !== 3'b010) begin
        errors++; $display("FAIL freeze[%0d] got v=%0b (%0d,%0d) b=%b p=%b exp v=1 (%0d,%0d) b=010 p=010",
                           k, ov[k], ox[k], oy[k], ob[k], op[k], mx[k], my[k]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    tick = 1'b1; xm = 9'd50; ym = 9'd20; btn = 3'b001;
    @(posedge clk); #1;
    tick = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ov[k] !== 1'b0 || ox[k] !== 10'd0 || oy[k] !== 9'd0 || ob[k] !== 3'b0) begin
          errors++; $display("FAIL inflight_reset[%0d] c%0d got v=%0b (%0d,%0d) b=%b exp v=0 (0,0) b=000", k, c, ov[k], ox[k], oy[k], ob[k]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_shift();
    send(4, 0, 3'b000, 1'b0);
    checks++;
    if (ox[1] !== 10'd16 || ox[0] !== 10'd4 || ox[2] !== 10'd32) begin
      errors++; $display("FAIL speed_shift got (%0d,%0d,%0d) exp (4,16,32)", ox[0], ox[1], ox[2]);
    end
  endtask

  task automatic test_back_to_back(input int n, input bit rnd);
    int         qx[$];
    int         qy[$];
    logic [2:0] qb[$];
    for (int c = 0; c <= n; c++) begin
      bit f;
      f = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      frz = f;
      if (c < n) begin
        int x;
        int y;
        logic [2:0] b;
        x = rnd ? rnd_delta() : c + 1;
        y = rnd ? rnd_delta() : 0;
        b = rnd ? 3'($urandom_range(0, 7)) : 3'b000;
        tick = 1'b1; xm = 9'(x); ym = 9'(y); btn = b;
        qx.push_back(x); qy.push_back(y); qb.push_back(b);
      end else begin
        tick = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= 1) begin
        model_apply(qx.pop_front(), qy.pop_front(), qb.pop_front(), f);
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (ov[k] !== 1'b1 || ox[k] !== 10'(mx[k]) || oy[k] !== 9'(my[k])) begin
            errors++; $display("FAIL b2b_pos[%0d] pkt%0d got v=%0b (%0d,%0d) exp v=1 (%0d,%0d)", k, c - 1, ov[k], ox[k], oy[k], mx[k], my[k]);
          end
          checks++;
          if (ob[k] !== mb || op[k] !== ep || orel[k] !== er || ocx[k] !== 10'(cx[k]) || ocy[k] !== 9'(cy[k])) begin
            errors++; $display("FAIL b2b_btn[%0d] pkt%0d got b=%b p=%b r=%b click=(%0d,%0d) exp b=%b p=%b r=%b click=(%0d,%0d)",
                               k, c - 1, ob[k], op[k], orel[k], ocx[k], ocy[k], mb, ep, er, cx[k], cy[k]);
          end
        end
      end
    end
    frz = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL b2b_tail_valid got %0b exp 0", ov[0]); end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(rnd_delta(), rnd_delta(), 3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ov[k] !== 1'b1 || ox[k] !== 10'(mx[k]) || oy[k] !== 9'(my[k]) || ob[k] !== mb || op[k] !== ep ||
            orel[k] !== er || ocx[k] !== 10'(cx[k]) || ocy[k] !== 9'(cy[k])) begin
          errors++; $display("FAIL random[%0d] pkt%0d got v=%0b (%0d,%0d) b=%b p=%b r=%b click=(%0d,%0d) exp (%0d,%0d) b=%b p=%b r=%b click=(%0d,%0d)",
                             k, i, ov[k], ox[k], oy[k], ob[k], op[k], orel[k], ocx[k], ocy[k],
                             mx[k], my[k], mb, ep, er, cx[k], cy[k]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_move();
    test_clamp();
    test_buttons();
    test_freeze();
    test_reset_inflight();
    test_shift();
    test_reset_inflight();
    test_back_to_back(3, 1'b0);
    test_back_to_back(40, 1'b1);
    test_random(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
